// File: rtl/svm_sched_pkg.sv
// Shared definitions for the batch filter engine.
// Holds the default widths and sizes, the FSM state encoding and the
// account hash that maps a dependency value onto a bitmap index.
package svm_sched_pkg;

  localparam int ID_W      = 64;
  localparam int NUM_DEPS  = 1024;
  localparam int HASH_BITS = 10;
  localparam int MAX_BATCH = 64;

  // Number of HASH_BITS-wide slices needed to cover an ID_W value
  localparam int FOLD_SLICES = (ID_W + HASH_BITS - 1) / HASH_BITS;

  typedef enum logic [2:0] {
    IDLE,
    CHK_R,
    CHK_W,
    COM_R,
    COM_W,
    RESULT
  } state_t;

  // XOR-fold: the value is cut into HASH_BITS slices starting at the LSB,
  // the top slice being zero-padded, and all slices are XORed together.
  function automatic logic [HASH_BITS-1:0] fold_hash(input logic [ID_W-1:0] value);
    logic [FOLD_SLICES*HASH_BITS-1:0] padded;
    logic [HASH_BITS-1:0]             h;
    padded = (FOLD_SLICES*HASH_BITS)'(value);
    h = '0;
    for (int s = 0; s < FOLD_SLICES; s++) begin
      h ^= padded[s*HASH_BITS +: HASH_BITS];
    end
    return h;
  endfunction

endpackage

// File: rtl/batch_filter_engine_if.sv
// Bus between the conflict checker (master) and the batch filter engine
// (slave).
//   transaction_forwarded : start pulse from the checker
//   owner_programID       : transaction ID, valid with the start pulse
//   read_dependencies     : NUM_DEPS read slots, slot i at [i*ID_W +: ID_W]
//   write_dependencies    : NUM_DEPS write slots, same layout
//   batch_flush           : clear the current batch
//   pipeline_ready        : engine can take a transaction
//   accept_valid          : pulse, transaction joined the batch
//   accepted_id           : ID of the last accepted transaction
//   has_conflict          : pulse, transaction was rejected
//   conflicting_id        : dependency value that caused the rejection
//   batch_count           : transactions currently in the batch
//   batch_full            : batch_count has reached MAX_BATCH
interface batch_filter_engine_if #(
  parameter int ID_W      = svm_sched_pkg::ID_W,
  parameter int NUM_DEPS  = svm_sched_pkg::NUM_DEPS,
  parameter int MAX_BATCH = svm_sched_pkg::MAX_BATCH
);
  localparam int CNT_W = $clog2(MAX_BATCH + 1);

  logic                     transaction_forwarded;
  logic [ID_W-1:0]          owner_programID;
  logic [NUM_DEPS*ID_W-1:0] read_dependencies;
  logic [NUM_DEPS*ID_W-1:0] write_dependencies;
  logic                     batch_flush;
  logic                     pipeline_ready;
  logic                     accept_valid;
  logic [ID_W-1:0]          accepted_id;
  logic                     has_conflict;
  logic [ID_W-1:0]          conflicting_id;
  logic [CNT_W-1:0]         batch_count;
  logic                     batch_full;

  modport master (
    output transaction_forwarded, owner_programID, read_dependencies,
           write_dependencies, batch_flush,
    input  pipeline_ready, accept_valid, accepted_id, has_conflict,
           conflicting_id, batch_count, batch_full
  );

  modport slave (
    input  transaction_forwarded, owner_programID, read_dependencies,
           write_dependencies, batch_flush,
    output pipeline_ready, accept_valid, accepted_id, has_conflict,
           conflicting_id, batch_count, batch_full
  );

endinterface

// File: rtl/account_bitmap.sv
// One hashed account bitmap of the current batch.
//   clk, rst_n  : clock, asynchronous active-low reset (clears all bits)
//   clear       : synchronous clear of every bit, wins over a set
//   set_valid   : set the bit at set_index on the next edge
//   set_index   : bit to set
//   test_index  : bit to look up
//   test_bit    : combinational value of the bit at test_index
module account_bitmap #(
  parameter int HASH_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 set_valid,
  input  logic [HASH_BITS-1:0] set_index,
  input  logic [HASH_BITS-1:0] test_index,
  output logic                 test_bit
);

  localparam int DEPTH = 1 << HASH_BITS;

  logic [DEPTH-1:0] bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (clear) begin
      bits <= '0;
    end else if (set_valid) begin
      bits[set_index] <= 1'b1;
    end
  end

  assign test_bit = bits[test_index];

endmodule

// File: rtl/batch_filter_engine.sv
// Batch filter engine: walks the read and write dependency lists of each
// forwarded transaction one slot per cycle against the batch's hashed
// read/write bitmaps, then either admits the transaction (committing its
// accounts) or rejects it with the first conflicting dependency value.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of batch_filter_engine_if (see that file)
module batch_filter_engine
  import svm_sched_pkg::*;
#(
  parameter int ID_W      = svm_sched_pkg::ID_W,
  parameter int NUM_DEPS  = svm_sched_pkg::NUM_DEPS,
  parameter int HASH_BITS = svm_sched_pkg::HASH_BITS,
  parameter int MAX_BATCH = svm_sched_pkg::MAX_BATCH
) (
  input logic                  clk,
  input logic                  rst_n,
  batch_filter_engine_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DEPS);
  localparam int CNT_W = $clog2(MAX_BATCH + 1);

  state_t state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [ID_W-1:0]      rd_slot [NUM_DEPS];
  logic [ID_W-1:0]      wr_slot [NUM_DEPS];
  logic [ID_W-1:0]      cur_val;
  logic                 slot_zero;
  logic                 list_end;
  logic [HASH_BITS-1:0] cur_hash;
  logic                 read_test;
  logic                 write_test;
  logic                 hit;
  logic                 set_read;
  logic                 set_write;
  logic                 start_ok;
  logic                 clear_sets;
  logic                 conflict;
  logic                 flush_pending;
  logic [ID_W-1:0]      cap_id;
  logic [ID_W-1:0]      hit_val;
  logic                 accept_q;
  logic                 reject_q;
  logic [ID_W-1:0]      accepted_q;
  logic [ID_W-1:0]      conflicting_q;
  logic [CNT_W-1:0]     count_q;
  logic                 full;

  for (genvar g = 0; g < NUM_DEPS; g++) begin : g_slots
    assign rd_slot[g] = bus.read_dependencies[g*ID_W +: ID_W];
    assign wr_slot[g] = bus.write_dependencies[g*ID_W +: ID_W];
  end

  assign full = (count_q == CNT_W'(MAX_BATCH));

  // A start is taken only while the engine is idle with room in the batch;
  // a flush in the same cycle wins and the start is dropped.
  assign start_ok = (state == IDLE) && bus.transaction_forwarded && !full &&
                    !flush_pending && !bus.batch_flush;

  // Bitmaps and count are cleared either directly from IDLE or, for a flush
  // that arrived mid-transaction, on the edge leaving RESULT.
  assign clear_sets = ((state == IDLE) && bus.batch_flush) ||
                      ((state == RESULT) && (flush_pending || bus.batch_flush));

  // Current slot: the write list is walked in CHK_W/COM_W, the read list
  // otherwise. A zero slot or the last slot ends the list.
  always_comb begin
    cur_val   = ((state == CHK_W) || (state == COM_W)) ? wr_slot[idx] : rd_slot[idx];
    slot_zero = (cur_val == '0);
    list_end  = slot_zero || (idx == IDX_W'(NUM_DEPS - 1));
    cur_hash  = fold_hash(cur_val);
  end

  account_bitmap #(.HASH_BITS(HASH_BITS)) u_read_set (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_sets),
    .set_valid  (set_read),
    .set_index  (cur_hash),
    .test_index (cur_hash),
    .test_bit   (read_test)
  );

  account_bitmap #(.HASH_BITS(HASH_BITS)) u_write_set (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_sets),
    .set_valid  (set_write),
    .set_index  (cur_hash),
    .test_index (cur_hash),
    .test_bit   (write_test)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Check passes only look at the bitmaps; commits happen afterwards, so a
  // transaction never conflicts with its own accounts.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    hit        = 1'b0;
    set_read   = 1'b0;
    set_write  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = CHK_R;
          idx_next   = '0;
        end
      end
      CHK_R: begin
        if (!slot_zero && write_test) begin
          hit        = 1'b1;
          state_next = RESULT;
          idx_next   = '0;
        end else if (list_end) begin
          state_next = CHK_W;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      CHK_W: begin
        if (!slot_zero && (write_test || read_test)) begin
          hit        = 1'b1;
          state_next = RESULT;
          idx_next   = '0;
        end else if (list_end) begin
          state_next = COM_R;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      COM_R: begin
        set_read = !slot_zero;
        if (list_end) begin
          state_next = COM_W;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      COM_W: begin
        set_write = !slot_zero;
        if (list_end) begin
          state_next = RESULT;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      RESULT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Result pulses are registered out of RESULT so they coincide with the
  // return to IDLE; a pending flush clears the count after the commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_id        <= '0;
      conflict      <= 1'b0;
      hit_val       <= '0;
      flush_pending <= 1'b0;
      accept_q      <= 1'b0;
      reject_q      <= 1'b0;
      accepted_q    <= '0;
      conflicting_q <= '0;
      count_q       <= '0;
    end else begin
      if (start_ok) begin
        cap_id   <= bus.owner_programID;
        conflict <= 1'b0;
      end
      if (hit) begin
        conflict <= 1'b1;
        hit_val  <= cur_val;
      end
      if (state == RESULT) begin
        flush_pending <= 1'b0;
      end else if ((state != IDLE) && bus.batch_flush) begin
        flush_pending <= 1'b1;
      end
      accept_q <= (state == RESULT) && !conflict;
      reject_q <= (state == RESULT) && conflict;
      if ((state == RESULT) && !conflict) begin
        accepted_q <= cap_id;
      end
      if ((state == RESULT) && conflict) begin
        conflicting_q <= hit_val;
      end
      if (clear_sets) begin
        count_q <= '0;
      end else if ((state == RESULT) && !conflict) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Combinational so the checker sees ready drop in its own forward cycle.
  assign bus.pipeline_ready = (state == IDLE) && !bus.transaction_forwarded &&
                              !full && !flush_pending;
  assign bus.accept_valid   = accept_q;
  assign bus.accepted_id    = accepted_q;
  assign bus.has_conflict   = reject_q;
  assign bus.conflicting_id = conflicting_q;
  assign bus.batch_count    = count_q;
  assign bus.batch_full     = full;

endmodule

// File: tb/tb_batch_filter_engine.sv
// Directed self-checking bench for batch_filter_engine: accept/reject
// latencies, result IDs, batch counting, full batch, flushes, hash aliasing,
// full-length lists and reset during a commit.
module tb_batch_filter_engine;

  localparam int ID_W      = 64;
  localparam int NUM_DEPS  = 1024;
  localparam int HASH_BITS = 10;
  localparam int MAX_BATCH = 64;

  logic clk = 1'b0;
  logic rst_n;

  int checkCount = 0;
  int passCount  = 0;

  logic [NUM_DEPS*ID_W-1:0] rd_deps;
  logic [NUM_DEPS*ID_W-1:0] wr_deps;
  int lat;
  bit got_acc;
  bit got_rej;
  bit saw_pulse;

  batch_filter_engine_if #(.ID_W(ID_W), .NUM_DEPS(NUM_DEPS), .MAX_BATCH(MAX_BATCH)) bus ();

  batch_filter_engine #(
    .ID_W      (ID_W),
    .NUM_DEPS  (NUM_DEPS),
    .HASH_BITS (HASH_BITS),
    .MAX_BATCH (MAX_BATCH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic void clearLists();
    rd_deps = '0;
    wr_deps = '0;
  endfunction

  function automatic void setRead(input int slot, input logic [63:0] val);
    rd_deps = rd_deps | ((NUM_DEPS*ID_W)'(val) << (slot*ID_W));
  endfunction

  function automatic void setWrite(input int slot, input logic [63:0] val);
    wr_deps = wr_deps | ((NUM_DEPS*ID_W)'(val) << (slot*ID_W));
  endfunction

  // Presents one transaction and counts cycles from the edge sampling the
  // start pulse until a result pulse; flush_at > 0 raises batch_flush for
  // one cycle after that many edges.
  task automatic applyStimulus(input logic [63:0] id, input int flush_at,
                               output int latency, output bit acc, output bit rej);
    bus.read_dependencies     = rd_deps;
    bus.write_dependencies    = wr_deps;
    bus.owner_programID       = id;
    bus.transaction_forwarded = 1'b1;
    #1;
    checkOutput("ready_during_start", 64'(bus.pipeline_ready), 64'(0));
    @(posedge clk); #1;
    bus.transaction_forwarded = 1'b0;
    latency = 0;
    acc = 1'b0;
    rej = 1'b0;
    while (!acc && !rej && latency < 5000) begin
      bus.batch_flush = (flush_at > 0) && (latency == flush_at);
      @(posedge clk); #1;
      latency++;
      acc = bus.accept_valid;
      rej = bus.has_conflict;
    end
    bus.batch_flush = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [63:0] id, input int flush_at,
                             input bit exp_acc, input int exp_lat,
                             input logic [63:0] exp_val, input int exp_count);
    applyStimulus(id, flush_at, lat, got_acc, got_rej);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_accept"}, 64'(got_acc), 64'(exp_acc));
    checkOutput({tag, "_reject"}, 64'(got_rej), 64'(!exp_acc));
    if (exp_acc) checkOutput({tag, "_accepted_id"}, bus.accepted_id, exp_val);
    else         checkOutput({tag, "_conflicting_id"}, bus.conflicting_id, exp_val);
    checkOutput({tag, "_count"}, 64'(bus.batch_count), 64'(exp_count));
  endtask

  task automatic watchPulses(input int cycles);
    saw_pulse = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.accept_valid || bus.has_conflict) saw_pulse = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.transaction_forwarded = 1'b0;
    bus.owner_programID       = '0;
    bus.batch_flush           = 1'b0;
    clearLists();
    bus.read_dependencies  = rd_deps;
    bus.write_dependencies = wr_deps;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_accept_valid", 64'(bus.accept_valid), 64'(0));
    checkOutput("rst_accepted_id", bus.accepted_id, 64'(0));
    checkOutput("rst_has_conflict", 64'(bus.has_conflict), 64'(0));
    checkOutput("rst_conflicting_id", bus.conflicting_id, 64'(0));
    checkOutput("rst_batch_count", 64'(bus.batch_count), 64'(0));
    checkOutput("rst_batch_full", 64'(bus.batch_full), 64'(0));
    checkOutput("rst_ready", 64'(bus.pipeline_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty lists: four one-cycle scans plus RESULT
    clearLists();
    runAndCheck("empty", 64'h11, 0, 1'b1, 5, 64'h11, 1);
    checkOutput("ready_with_pulse", 64'(bus.pipeline_ready), 64'(1));
    @(posedge clk); #1;
    checkOutput("accept_one_cycle", 64'(bus.accept_valid), 64'(0));

    // Write 0xA5, then a read of 0xA5 hits on slot 0
    clearLists(); setWrite(0, 64'hA5);
    runAndCheck("wr_a5", 64'h21, 0, 1'b1, 7, 64'h21, 2);
    clearLists(); setRead(0, 64'hA5);
    runAndCheck("rd_a5", 64'h22, 0, 1'b0, 2, 64'hA5, 2);
    checkOutput("accepted_id_held", bus.accepted_id, 64'h21);

    // Two readers of 0x77 coexist; a writer of 0x77 is then rejected
    clearLists(); setRead(0, 64'h77);
    runAndCheck("rd77_a", 64'h31, 0, 1'b1, 7, 64'h31, 3);
    runAndCheck("rd77_b", 64'h32, 0, 1'b1, 7, 64'h32, 4);
    clearLists(); setWrite(0, 64'h77);
    runAndCheck("wr77", 64'h33, 0, 1'b0, 3, 64'h77, 4);

    // Self read/write overlap is not a conflict
    clearLists(); setRead(0, 64'h5); setWrite(0, 64'h5);
    runAndCheck("self_rw", 64'h41, 0, 1'b1, 9, 64'h41, 5);

    // 0xA5 after the terminating zero is ignored
    clearLists(); setRead(0, 64'h33); setRead(2, 64'hA5);
    runAndCheck("after_zero", 64'h51, 0, 1'b1, 7, 64'h51, 6);

    // Flush during CHK_R applies once RESULT has committed
    clearLists(); setRead(0, 64'h10); setRead(1, 64'h11); setRead(2, 64'h12);
    runAndCheck("mid_flush", 64'h61, 1, 1'b1, 11, 64'h61, 0);
    checkOutput("mid_flush_ready", 64'(bus.pipeline_ready), 64'(1));
    clearLists(); setRead(0, 64'hA5);
    runAndCheck("a5_after_flush", 64'h62, 0, 1'b1, 7, 64'h62, 1);

    // Fill the batch
    clearLists(); setWrite(0, 64'h99);
    runAndCheck("wr99", 64'h63, 0, 1'b1, 7, 64'h63, 2);
    clearLists();
    for (int k = 0; k < 62; k++) applyStimulus(64'(256 + k), 0, lat, got_acc, got_rej);
    checkOutput("full_count", 64'(bus.batch_count), 64'(64));
    checkOutput("full_flag", 64'(bus.batch_full), 64'(1));
    checkOutput("full_ready", 64'(bus.pipeline_ready), 64'(0));

    // A start while not ready is ignored
    bus.owner_programID = 64'hEE;
    bus.transaction_forwarded = 1'b1;
    @(posedge clk); #1;
    bus.transaction_forwarded = 1'b0;
    watchPulses(8);
    checkOutput("ignored_start_pulse", 64'(saw_pulse), 64'(0));
    checkOutput("ignored_start_count", 64'(bus.batch_count), 64'(64));

    // Flush from IDLE
    bus.batch_flush = 1'b1;
    @(posedge clk); #1;
    bus.batch_flush = 1'b0;
    checkOutput("flush_count", 64'(bus.batch_count), 64'(0));
    checkOutput("flush_full", 64'(bus.batch_full), 64'(0));
    checkOutput("flush_ready", 64'(bus.pipeline_ready), 64'(1));
    clearLists(); setRead(0, 64'h99);
    runAndCheck("rd99_after_flush", 64'h64, 0, 1'b1, 7, 64'h64, 1);

    // Hash aliasing: 0x400 and bit 60 both fold onto index 1
    clearLists(); setWrite(0, 64'h400);
    runAndCheck("wr400", 64'h70, 0, 1'b1, 7, 64'h70, 2);
    clearLists(); setRead(0, 64'h1);
    runAndCheck("alias_1", 64'h71, 0, 1'b0, 2, 64'h1, 2);
    clearLists(); setRead(0, 64'h1000_0000_0000_0000);
    runAndCheck("alias_top", 64'h72, 0, 1'b0, 2, 64'h1000_0000_0000_0000, 2);
    checkOutput("alias_accepted_held", bus.accepted_id, 64'h70);

    // Reset while in COM_W
    clearLists(); setWrite(0, 64'h88);
    bus.read_dependencies  = rd_deps;
    bus.write_dependencies = wr_deps;
    bus.owner_programID = 64'h80;
    bus.transaction_forwarded = 1'b1;
    @(posedge clk); #1;
    bus.transaction_forwarded = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_count", 64'(bus.batch_count), 64'(0));
    checkOutput("midrst_accepted_id", bus.accepted_id, 64'(0));
    checkOutput("midrst_conflicting_id", bus.conflicting_id, 64'(0));
    checkOutput("midrst_ready", 64'(bus.pipeline_ready), 64'(1));
    watchPulses(3);
    checkOutput("midrst_no_pulse", 64'(saw_pulse), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    clearLists(); setRead(0, 64'h400);
    runAndCheck("rd400_after_rst", 64'h81, 0, 1'b1, 7, 64'h81, 1);
    clearLists(); setWrite(0, 64'h88);
    runAndCheck("wr88_after_rst", 64'h82, 0, 1'b1, 7, 64'h82, 2);

    // Full-length read list: NUM_DEPS cycles in each read pass
    bus.batch_flush = 1'b1;
    @(posedge clk); #1;
    bus.batch_flush = 1'b0;
    clearLists();
    for (int i = 0; i < NUM_DEPS; i++) setRead(i, 64'(i + 1));
    runAndCheck("full_list", 64'h90, 0, 1'b1, 2051, 64'h90, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
